uart_rx_capture: RTL and testbench
==================================

# uart_rx_capture

Oversampling 8N1 UART receiver for the Murax board top level. It is the receiving end of the SoC's serial output, taking its input from `io_uart_txd`. It recovers bytes and presents them on a valid/ready byte interface, so the board top can latch them for display on `io_led` or loop them back. It detects false starts, framing errors and overruns; all logic runs in the single main clock domain.

## Interface
- `CLKS_PER_SAMPLE`, default 54: main-clock cycles per oversample tick. 100 MHz / (115200 × 16) ≈ 54. Legal range is 2..1023.
- `OVERSAMPLE`, default 16: sample ticks per bit. The value is fixed at 16; other values are unsupported.
- `io_mainClk` input, 1 bit: the single clock. All state updates on its rising edge.
- `io_resetn` input, 1 bit: reset, synchronous and active-low.
- `io_rxd` input, 1 bit: serial line, asynchronous. The idle level is 1.
- `rx_data` output, 8 bits: received byte, LSB first on the wire. It is stable while `rx_valid` is high.
- `rx_valid` output, 1 bit: a byte is available. It stays high until accepted.
- `rx_ready` input, 1 bit: the consumer accepts the byte when `rx_valid && rx_ready`.
- `frame_err` output, 1 bit: one-cycle pulse when a stop bit is sampled as 0.
- `overrun` output, 1 bit: sticky flag, set when a byte completes while `rx_valid` is still high.
- `overrun_clr` input, 1 bit: clears `overrun`.

## Operation
- `io_rxd` passes through a 2-flop synchronizer, initialised to 1 by reset. All logic below uses the synchronized value `rxs`.
- The tick counter runs 0..`CLKS_PER_SAMPLE`-1 and emits `tick` on the terminal count. The counter is held at 0 while in IDLE.
- A sample counter counts 0..15 within each bit. Samples 7, 8 and 9 are majority-voted to give the bit value, which is taken at sample 9.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: a 1→0 transition on `rxs` moves to START and clears both counters.
- START: at sample 9, if the voted value is 1 this is a false start; return to IDLE. If it is 0, move to DATA with bit index 0.
- DATA: at sample 9 of each bit, shift the voted bit into the MSB of the shift register (right shift). After bit index 7, move to STOP.
- STOP, voted stop bit = 1:
  - Load `rx_data` and set `rx_valid`.
  - If `rx_valid` was already high and not accepted in the same cycle, keep the old `rx_data`, drop the new byte and set `overrun`.
  - Return to IDLE.
- STOP, voted stop bit = 0: pulse `frame_err`, drop the byte, go to WAIT_IDLE.
- WAIT_IDLE: remain until `rxs` = 1, then go to IDLE. This prevents a break condition from being read as repeated start bits.
- Accept and load in the same cycle: if `rx_valid && rx_ready` coincides with a new good byte, load the new byte. `rx_valid` stays high and `overrun` is not set.
- `overrun_clr` and an overrun-set event in the same cycle: set wins.
- Reset values:
  - `rx_data` = 0x00, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0.
  - State = IDLE, counters = 0, synchronizer = 1.
- Reset mid-frame: the partial byte is discarded. After reset the receiver stays in IDLE until the next 1→0 edge. A line held low at reset release does not start a frame.

## Timing
- Sample ticks are measured from the cycle START is entered. Each tick is `CLKS_PER_SAMPLE` cycles.
  - Start vote: tick 9.
  - Data bit k vote: tick 16·(k+1)+9.
  - Stop vote: tick 153.
- `rx_valid` (or the `frame_err` pulse) is registered one cycle after the stop vote tick.
- Pin-to-detect latency: 2 cycles through the synchronizer plus 1 cycle of edge detect.
- `rx_ready` has no combinational path to any output. `rx_valid` drops the cycle after acceptance.
- The earliest point at which the next start edge is recognised is the cycle after the return to IDLE. This is mid-stop-bit, which tolerates a sender running about 3% fast.

## Structure
- Shared package `uart_pkg`:
  - State enum `uart_rx_state_t`.
  - Constant `UART_OVERSAMPLE = 16`.
  - Vote sample indices `UART_VOTE_LO = 7`, `UART_VOTE_HI = 9`.
  - Helper constant for the default 100 MHz / 115200 divider (54).
- Sub-module `uart_baud_tick`: parameterised tick generator with an enable (tick counter only). It is reused by a future `uart_tx` block.
- The synchronizer is inline.

## Test plan
- `CLKS_PER_SAMPLE` = 4. Send 0x55, then 0xA3, with `rx_ready` held at 1 → two `rx_valid` pulses with `rx_data` 0x55 and 0xA3; `frame_err` = 0 and `overrun` = 0 throughout.
- Low glitch on `io_rxd` lasting 5 sample ticks, then the line idles → no `rx_valid`. The state returns to IDLE at tick 9. A following 0x0F is received correctly.
- Frame 0x3C with the stop bit forced to 0, then the line held low for 2 bit times → a single `frame_err` pulse and no `rx_valid`. The next frame, 0x81, is received as 0x81.
- Send 0x11 then 0x22 back to back with `rx_ready` = 0 → `rx_data` stays 0x11 and `overrun` = 1. Raise `rx_ready` and pulse `overrun_clr` → `rx_valid` drops and `overrun` = 0.
- Assert `io_resetn` = 0 for 3 cycles during data bit 4 of 0xC7 → outputs read 0 after reset and no byte is delivered. A subsequent 0x5A is received correctly.
- With `rx_valid` high, assert `rx_ready` in the exact cycle the stop vote of 0x99 completes → `rx_data` = 0x99, `rx_valid` stays 1 and `overrun` stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Purpose: shared types and constants for the UART blocks (rx now, tx later).
// Latency: n/a (package only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } uart_rx_state_t;

  localparam int UART_OVERSAMPLE = 16;

  // Samples 7, 8 and 9 of each bit are majority-voted; the decision is made at 9.
  localparam logic [3:0] UART_VOTE_LO = 4'd7;
  localparam logic [3:0] UART_VOTE_HI = 4'd9;

  // 100 MHz / (115200 * 16) rounded to the nearest integer.
  localparam int UART_CLKS_100M_115200 = 54;

  function automatic logic uart_vote3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Purpose: oversample tick generator; counts 0..CLKS_PER_SAMPLE-1 while enabled.
// Latency: first tick CLKS_PER_SAMPLE-1 cycles after enable rises, then every CLKS_PER_SAMPLE.
// Backpressure: none; counter is held at 0 while i_en is low.
// Ports: i_clk clock, i_resetn sync active-low reset, i_en run enable, o_tick one-cycle tick.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_SAMPLE = UART_CLKS_100M_115200
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_en,
  output logic o_tick
);

  localparam int             W    = $clog2(CLKS_PER_SAMPLE);
  localparam logic [W-1:0]   LAST = W'(CLKS_PER_SAMPLE - 1);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = i_en & w_last;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_cnt <= '0;
    end else if (!i_en || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_capture.sv
// Purpose: 16x oversampling 8N1 UART receiver with false-start, framing and overrun detection.
// Latency: rx_valid rises 1 cycle after the stop-bit vote (tick 153 after START, START 3 cycles after the pin falls).
// Backpressure: rx_valid/rx_data hold until rx_ready; a byte completing while still held is dropped and sets overrun.
// Ports: io_mainClk clock, io_resetn sync active-low reset, io_rxd async serial line (idle 1),
//        rx_data/rx_valid/rx_ready byte handshake, frame_err 1-cycle pulse, overrun sticky flag, overrun_clr clears it.
module uart_rx_capture
  import uart_pkg::*;
#(
  parameter int CLKS_PER_SAMPLE = UART_CLKS_100M_115200,
  parameter int OVERSAMPLE      = UART_OVERSAMPLE
) (
  input  logic       io_mainClk,
  input  logic       io_resetn,
  input  logic       io_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       overrun_clr
);

  localparam logic [3:0] SAMP_LAST = 4'(OVERSAMPLE - 1);

  // Synchronizer and edge detect
  logic       r_sync1;
  logic       r_rxs;
  logic       r_rxs_d;
  // Fills with ones after reset; bit 2 set means r_rxs_d holds a real pin sample,
  // so a line already low at reset release is not mistaken for a 1->0 edge.
  logic [2:0] r_fill;
  logic       w_fall;

  always_ff @(posedge io_mainClk) begin
    if (!io_resetn) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
      r_rxs_d <= 1'b1;
      r_fill  <= 3'b000;
    end else begin
      r_sync1 <= io_rxd;
      r_rxs   <= r_sync1;
      r_rxs_d <= r_rxs;
      r_fill  <= {r_fill[1:0], 1'b1};
    end
  end

  assign w_fall = r_fill[2] & r_rxs_d & ~r_rxs;

  // Oversample tick
  uart_rx_state_t r_state;
  logic           w_tick_en;
  logic           w_tick;

  assign w_tick_en = (r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP);

  uart_baud_tick #(
    .CLKS_PER_SAMPLE (CLKS_PER_SAMPLE)
  ) u_tick (
    .i_clk    (io_mainClk),
    .i_resetn (io_resetn),
    .i_en     (w_tick_en),
    .o_tick   (w_tick)
  );

  // Sample position within the bit and the vote
  logic [3:0] r_samp;
  logic [3:0] w_samp_nxt;
  logic [1:0] r_hist;      // samples VOTE_LO and VOTE_LO+1 of the current bit
  logic       w_vote_now;
  logic       w_vote;
  logic [2:0] r_bit;
  logic [7:0] r_shift;

  assign w_samp_nxt = (r_samp == SAMP_LAST) ? 4'd0 : r_samp + 4'd1;
  assign w_vote_now = w_tick && (w_samp_nxt == UART_VOTE_HI);
  assign w_vote     = uart_vote3(r_hist[1], r_hist[0], r_rxs);

  always_ff @(posedge io_mainClk) begin
    if (!io_resetn) begin
      r_state   <= ST_IDLE;
      r_samp    <= 4'd0;
      r_hist    <= 2'b00;
      r_bit     <= 3'd0;
      r_shift   <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (overrun_clr) begin
        overrun <= 1'b0;
      end

      if (w_tick) begin
        r_samp <= w_samp_nxt;
        if ((w_samp_nxt >= UART_VOTE_LO) && (w_samp_nxt < UART_VOTE_HI)) begin
          r_hist <= {r_hist[0], r_rxs};
        end
      end

      // Later assignments below win: a load beats the accept-clear and an
      // overrun set beats overrun_clr.
      case (r_state)
        ST_IDLE: begin
          r_samp <= 4'd0;
          if (w_fall) begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_vote_now) begin
            if (w_vote) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_DATA;
              r_bit   <= 3'd0;
            end
          end
        end
        ST_DATA: begin
          if (w_vote_now) begin
            r_shift <= {w_vote, r_shift[7:1]};
            if (r_bit == 3'd7) begin
              r_state <= ST_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (w_vote_now) begin
            if (w_vote) begin
              if (rx_valid && !rx_ready) begin
                overrun <= 1'b1;
              end else begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
              end
              r_state <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              r_state   <= ST_WAIT_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          // Hold off through a break so a long low is not read as new start bits.
          if (r_rxs) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_capture.sv
// Purpose: self-checking bench for uart_rx_capture with directed and random frames.
// Latency: n/a.
// Backpressure: rx_ready driven by the bench per scenario.
module tb_uart_rx_capture;

  localparam int CPS       = 4;
  localparam int BIT       = 16 * CPS;
  // Pin to START: 2 synchronizer cycles + 1 edge-detect cycle; stop vote at tick 153.
  localparam int STOP_EDGE = 3 + 153 * CPS;

  logic       clk    = 1'b0;
  logic       resetn = 1'b0;
  logic       rxd    = 1'b1;
  logic       ready  = 1'b0;
  logic       oclr   = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       ovr;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  uart_rx_capture #(
    .CLKS_PER_SAMPLE (CPS),
    .OVERSAMPLE      (16)
  ) dut (
    .io_mainClk  (clk),
    .io_resetn   (resetn),
    .io_rxd      (rxd),
    .rx_data     (data),
    .rx_valid    (valid),
    .rx_ready    (ready),
    .frame_err   (ferr),
    .overrun     (ovr),
    .overrun_clr (oclr)
  );

  always #5 clk = ~clk;

  // Consumer-side observation: a byte is taken when valid && ready before the edge.
  always @(negedge clk) begin
    if (resetn) begin
      if (valid && ready) got_q.push_back(data);
      if (ferr) ferr_cnt++;
      if (ovr) ovr_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one 8N1 frame, LSB first; the stop level is held for 1+extra_low bit times.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int extra_low);
    rxd = 1'b0;
    repeat (BIT) step();
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (BIT) step();
    end
    rxd = stop;
    repeat (BIT * (1 + extra_low)) step();
    rxd = 1'b1;
  endtask

  task automatic score(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    int gap;

    // Reset values
    resetn = 1'b0;
    repeat (4) step();
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data",  32'(data),  32'h00);
    check("rst_ferr",  32'(ferr),  32'd0);
    check("rst_ovr",   32'(ovr),   32'd0);
    resetn = 1'b1;
    repeat (20) step();

    // Two frames with ready held high
    ferr_cnt = 0; ovr_cnt = 0;
    ready = 1'b1;
    send_frame(8'h55, 1'b1, 0); exp_q.push_back(8'h55);
    send_frame(8'hA3, 1'b1, 0); exp_q.push_back(8'hA3);
    repeat (10) step();
    score("basic");
    check("basic_ferr", 32'(ferr_cnt), 32'd0);
    check("basic_ovr",  32'(ovr_cnt),  32'd0);

    // False start: low for 5 ticks only
    rxd = 1'b0;
    repeat (5 * CPS) step();
    rxd = 1'b1;
    repeat (3 * BIT) step();
    check("glitch_nobyte", 32'(got_q.size()), 32'd0);
    check("glitch_valid",  32'(valid), 32'd0);
    send_frame(8'h0F, 1'b1, 0); exp_q.push_back(8'h0F);
    repeat (10) step();
    score("glitch_next");

    // Framing error followed by a 2-bit break
    ferr_cnt = 0;
    send_frame(8'h3C, 1'b0, 2);
    repeat (BIT) step();
    check("ferr_pulses", 32'(ferr_cnt), 32'd1);
    check("ferr_nobyte", 32'(got_q.size()), 32'd0);
    check("ferr_valid",  32'(valid), 32'd0);
    send_frame(8'h81, 1'b1, 0); exp_q.push_back(8'h81);
    repeat (10) step();
    score("ferr_next");

    // Overrun: two frames with nobody accepting
    ready = 1'b0;
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    check("ovr_valid", 32'(valid), 32'd1);
    check("ovr_data",  32'(data),  32'h11);
    check("ovr_flag",  32'(ovr),   32'd1);
    ready = 1'b1; oclr = 1'b1;
    step();
    ready = 1'b0; oclr = 1'b0;
    check("ovr_drop_valid", 32'(valid), 32'd0);
    check("ovr_cleared",    32'(ovr),   32'd0);
    exp_q.push_back(8'h11);
    score("ovr");

    // Accept in the exact cycle a new byte loads
    send_frame(8'h42, 1'b1, 0);
    check("same_pre_valid", 32'(valid), 32'd1);
    fork
      send_frame(8'h99, 1'b1, 0);
      begin
        repeat (STOP_EDGE - 1) step();
        check("same_old_data", 32'(data), 32'h42);
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("same_new_data", 32'(data),  32'h99);
        check("same_valid",    32'(valid), 32'd1);
        check("same_ovr",      32'(ovr),   32'd0);
      end
    join
    exp_q.push_back(8'h42);
    score("same");

    // Reset during data bit 4 of 0xC7 (line low at release)
    fork
      send_frame(8'hC7, 1'b1, 0);
      begin
        repeat (5 * BIT + 20) step();
        resetn = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_data",  32'(data),  32'h00);
        check("midrst_ovr",   32'(ovr),   32'd0);
        check("midrst_ferr",  32'(ferr),  32'd0);
      end
    join
    repeat (BIT) step();
    check("midrst_nobyte", 32'(got_q.size()), 32'd0);
    check("midrst_idle",   32'(valid), 32'd0);
    ready = 1'b1;
    send_frame(8'h5A, 1'b1, 0); exp_q.push_back(8'h5A);
    repeat (10) step();
    score("midrst_next");

    // Random bytes with random idle gaps (including back-to-back)
    for (int k = 0; k < 6; k++) begin
      d   = 8'($urandom_range(0, 255));
      gap = int'($urandom_range(0, 40));
      send_frame(d, 1'b1, 0);
      exp_q.push_back(d);
      repeat (gap) step();
    end
    repeat (20) step();
    score("rand");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
